// File: rtl/spi_slave.sv
// SPI mode-3 register-access responder; SCLK/SS/MOSI are oversampled in the clk domain.
// A command byte {rw, ms, addr[5:0]} selects a register read (rw=1) or write (rw=0).
module spi_slave #(
  parameter int ADDR_W      = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              SCLK,
  input  logic              SS,
  input  logic              MOSI,
  output logic              MISO,
  output logic              MISO_OE,
  output logic [ADDR_W-1:0] reg_addr,
  input  logic [7:0]        reg_rdata,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              busy,
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    LOAD = 2'd2,
    DATA = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] sclk_sr, ss_sr, mosi_sr;
  logic                   sclk_prev, ss_prev;
  logic                   sclk_s, ss_s, mosi_s;
  logic                   rise, fall, ss_fall, ss_rise;

  logic [7:0] shreg;
  logic [7:0] byte_in;
  logic [2:0] bit_cnt;
  logic       last_rise;
  logic       rw, ms;
  logic       armed;        // a data bit was sampled; the next fall advances MISO
  logic       reload;       // one cycle after a read byte ends: fetch the next byte
  logic       reload_fall;  // next fall presents bit7 of the freshly loaded byte

  // All three inputs share one synchronizer depth so MOSI stays aligned with SCLK.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sr   <= '1;
      ss_sr     <= '1;
      mosi_sr   <= '0;
      sclk_prev <= 1'b1;
      ss_prev   <= 1'b1;
    end else begin
      sclk_sr   <= {sclk_sr[SYNC_STAGES-2:0], SCLK};
      ss_sr     <= {ss_sr[SYNC_STAGES-2:0], SS};
      mosi_sr   <= {mosi_sr[SYNC_STAGES-2:0], MOSI};
      sclk_prev <= sclk_s;
      ss_prev   <= ss_s;
    end
  end

  assign sclk_s    = sclk_sr[SYNC_STAGES-1];
  assign ss_s      = ss_sr[SYNC_STAGES-1];
  assign mosi_s    = mosi_sr[SYNC_STAGES-1];
  assign rise      = ~sclk_prev & sclk_s;
  assign fall      = sclk_prev & ~sclk_s;
  assign ss_fall   = ss_prev & ~ss_s;
  assign ss_rise   = ~ss_prev & ss_s;
  assign byte_in   = {shreg[6:0], mosi_s};
  assign last_rise = rise && (bit_cnt == 3'd7);
  assign fsm_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (ss_fall) state_n = CMD;
      CMD:  if (last_rise) state_n = byte_in[7] ? LOAD : DATA;
      LOAD: state_n = DATA;
      DATA: state_n = DATA;
      default: state_n = IDLE;
    endcase
    if (ss_rise) state_n = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      MISO        <= 1'b0;
      MISO_OE     <= 1'b0;
      reg_addr    <= '0;
      reg_wdata   <= 8'h00;
      reg_we      <= 1'b0;
      busy        <= 1'b0;
      shreg       <= 8'h00;
      bit_cnt     <= 3'd0;
      rw          <= 1'b0;
      ms          <= 1'b0;
      armed       <= 1'b0;
      reload      <= 1'b0;
      reload_fall <= 1'b0;
    end else begin
      reg_we <= 1'b0;
      reload <= 1'b0;
      // Writes advance the address only after the strobe cycle has shown the old one.
      if (reg_we && ms) reg_addr <= reg_addr + ADDR_ONE;

      case (state)
        IDLE: begin
          MISO        <= 1'b0;
          MISO_OE     <= 1'b0;
          bit_cnt     <= 3'd0;
          armed       <= 1'b0;
          reload_fall <= 1'b0;
          if (ss_fall) busy <= 1'b1;
        end
        CMD: begin
          if (rise) begin
            shreg   <= byte_in;
            bit_cnt <= bit_cnt + 3'd1;
          end
          if (last_rise) begin
            rw       <= byte_in[7];
            ms       <= byte_in[6];
            reg_addr <= byte_in[ADDR_W-1:0];
          end
        end
        LOAD: begin
          shreg       <= reg_rdata;
          MISO        <= reg_rdata[7];
          MISO_OE     <= 1'b1;
          armed       <= 1'b0;
          reload_fall <= 1'b0;
        end
        DATA: begin
          if (rw) begin
            if (reload) begin
              shreg       <= reg_rdata;
              reload_fall <= 1'b1;
            end else if (fall) begin
              if (reload_fall) begin
                MISO        <= shreg[7];
                reload_fall <= 1'b0;
              end else if (armed) begin
                MISO  <= shreg[6];
                shreg <= {shreg[6:0], 1'b0};
                armed <= 1'b0;
              end
            end
            if (rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              armed   <= (bit_cnt != 3'd7);
            end
            if (last_rise) begin
              reload <= 1'b1;
              if (ms) reg_addr <= reg_addr + ADDR_ONE;
            end
          end else begin
            if (rise) begin
              shreg   <= byte_in;
              bit_cnt <= bit_cnt + 3'd1;
            end
            if (last_rise) begin
              reg_wdata <= byte_in;
              reg_we    <= 1'b1;
            end
          end
        end
        default: ;
      endcase

      // Deselect wins over everything except a write byte completing on the same cycle.
      if (ss_rise) begin
        busy        <= 1'b0;
        MISO        <= 1'b0;
        MISO_OE     <= 1'b0;
        bit_cnt     <= 3'd0;
        armed       <= 1'b0;
        reload      <= 1'b0;
        reload_fall <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a mode-3 SPI master, a bench-owned register file, and
// read/write scoreboards fed as stimulus is driven.
module tb_spi_slave;

  localparam int HP = 6;

  logic       clk = 1'b0;
  logic       reset;
  logic       SCLK, SS, MOSI;
  logic       MISO, MISO_OE;
  logic [5:0] reg_addr;
  logic [7:0] reg_rdata;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       busy;
  logic [1:0] fsm_state;

  logic [7:0]  regfile [64];
  logic [7:0]  rd_exp_q[$];
  logic [13:0] wr_exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clk = ~clk;

  spi_slave #(.ADDR_W(6), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .SCLK(SCLK), .SS(SS), .MOSI(MOSI),
    .MISO(MISO), .MISO_OE(MISO_OE), .reg_addr(reg_addr), .reg_rdata(reg_rdata),
    .reg_wdata(reg_wdata), .reg_we(reg_we), .busy(busy), .fsm_state(fsm_state)
  );

  assign reg_rdata = regfile[reg_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Write scoreboard: every strobe must match the oldest expected {addr, data}.
  always @(negedge clk) begin
    if (!reset && reg_we) begin
      if (wr_exp_q.size() == 0) check("we_unexpected", 32'(wr_exp_q.size()), 32'd1);
      else check("we_addr_data", {18'd0, reg_addr, reg_wdata}, {18'd0, wr_exp_q.pop_front()});
    end
  end

  task automatic spi_byte(input logic [7:0] tx, input logic oe_exp,
                          output logic [7:0] rx, output logic [5:0] addr0);
    for (int i = 7; i >= 0; i--) begin
      SCLK = 1'b0;
      MOSI = tx[i];
      wait_clk(HP);
      rx[i] = MISO;
      if (i == 7) addr0 = reg_addr;
      check("miso_oe", 32'(MISO_OE), 32'(oe_exp));
      SCLK = 1'b1;
      wait_clk(HP);
    end
  endtask

  task automatic start_txn();
    SS = 1'b0;
    wait_clk(HP);
    check("busy_on", 32'(busy), 32'd1);
  endtask

  task automatic end_txn();
    wait_clk(HP);
    SS = 1'b1;
    wait_clk(2 * HP);
    check("busy_off", 32'(busy), 32'd0);
    check("state_idle", 32'(fsm_state), 32'd0);
    check("oe_off", 32'(MISO_OE), 32'd0);
  endtask

  task automatic read_txn(input logic [5:0] addr, input logic ms, input int n);
    logic [7:0] rx;
    logic [5:0] a, exp_a;
    start_txn();
    spi_byte({1'b1, ms, addr}, 1'b0, rx, a);
    for (int k = 0; k < n; k++) begin
      exp_a = ms ? addr + 6'(k) : addr;
      rd_exp_q.push_back(regfile[exp_a]);
      spi_byte(8'h00, 1'b1, rx, a);
      check("rd_addr", 32'(a), 32'(exp_a));
      check("rd_data", 32'(rx), 32'(rd_exp_q.pop_front()));
    end
    end_txn();
  endtask

  task automatic write_txn(input logic [5:0] addr, input logic ms, input int n, input logic [7:0] d0);
    logic [7:0] rx, d;
    logic [5:0] a, exp_a;
    start_txn();
    spi_byte({1'b0, ms, addr}, 1'b0, rx, a);
    for (int k = 0; k < n; k++) begin
      exp_a = ms ? addr + 6'(k) : addr;
      d = d0 + 8'(k);
      wr_exp_q.push_back({exp_a, d});
      spi_byte(d, 1'b0, rx, a);
    end
    end_txn();
    check("wr_queue_drained", 32'(wr_exp_q.size()), 32'd0);
    exp_a = ms ? addr + 6'(n) : addr;
    check("wr_addr_end", 32'(reg_addr), 32'(exp_a));
  endtask

  initial begin
    logic [7:0] rx;
    logic [5:0] a, ra;
    for (int i = 0; i < 64; i++) regfile[i] = 8'($urandom_range(0, 255));
    regfile[6'h0F] = 8'hD3;
    regfile[6'h3E] = 8'h11;
    regfile[6'h3F] = 8'h22;
    regfile[6'h00] = 8'h33;

    reset = 1'b1; SCLK = 1'b1; SS = 1'b1; MOSI = 1'b0;
    wait_clk(3);
    check("rst_miso", 32'(MISO), 32'd0);
    check("rst_oe", 32'(MISO_OE), 32'd0);
    check("rst_addr", 32'(reg_addr), 32'd0);
    check("rst_wdata", 32'(reg_wdata), 32'd0);
    check("rst_we", 32'(reg_we), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(fsm_state), 32'd0);
    reset = 1'b0;
    wait_clk(4);

    // SCLK toggling while deselected must not start anything.
    for (int i = 0; i < 4; i++) begin
      SCLK = 1'b0; wait_clk(HP); SCLK = 1'b1; wait_clk(HP);
    end
    check("desel_state", 32'(fsm_state), 32'd0);
    check("desel_busy", 32'(busy), 32'd0);

    read_txn(6'h0F, 1'b0, 1);
    read_txn(6'h3E, 1'b1, 3);
    write_txn(6'h20, 1'b0, 1, 8'h0F);
    write_txn(6'h20, 1'b1, 2, 8'hA1);
    write_txn(6'h20, 1'b0, 2, 8'hA1);

    // Aborted write: 5 data bits, then deselect.
    start_txn();
    spi_byte(8'h20, 1'b0, rx, a);
    for (int i = 0; i < 5; i++) begin
      SCLK = 1'b0; MOSI = 1'b1; wait_clk(HP); SCLK = 1'b1; wait_clk(HP);
    end
    end_txn();
    check("abort_addr", 32'(reg_addr), 32'h20);
    write_txn(6'h25, 1'b0, 1, 8'h5A);

    // Command byte only.
    start_txn();
    spi_byte(8'h61, 1'b0, rx, a);
    end_txn();

    // Reset in the middle of data bit 3 of a read.
    start_txn();
    spi_byte(8'h8F, 1'b0, rx, a);
    for (int i = 0; i < 2; i++) begin
      SCLK = 1'b0; wait_clk(HP); SCLK = 1'b1; wait_clk(HP);
    end
    SCLK = 1'b0;
    wait_clk(HP / 2);
    #2 reset = 1'b1;
    #1;
    check("midrst_oe", 32'(MISO_OE), 32'd0);
    check("midrst_addr", 32'(reg_addr), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_miso", 32'(MISO), 32'd0);
    SS = 1'b1; SCLK = 1'b1;
    wait_clk(4);
    reset = 1'b0;
    wait_clk(4);
    read_txn(6'h0F, 1'b0, 1);

    for (int r = 0; r < 3; r++) begin
      ra = 6'($urandom_range(0, 63));
      write_txn(ra, 1'($urandom_range(0, 1)), $urandom_range(1, 2), 8'($urandom_range(0, 255)));
      read_txn(ra, 1'($urandom_range(0, 1)), 2);
    end

    wait_clk(10);
    check("final_wr_queue", 32'(wr_exp_q.size()), 32'd0);
    check("final_rd_queue", 32'(rd_exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI responder (mode 3: CPOL=1, CPHA=1) that models the far end of the gyro/accelerometer SPI links.
- Decodes a command byte (R/W, multi-byte, 6-bit address), then reads from or writes to a local register interface.
- Used behind SS_G/SS_A in system benches in place of toggling MISO stimulus, and as a synthesizable register-access slave.
- SPI inputs are oversampled in the clk domain; no logic is clocked by SCLK.

Parameters:
- ADDR_W, 6, register address width (command byte bits [5:0]).
- SYNC_STAGES, 2, synchronizer depth on SCLK, SS, MOSI (minimum 2).

Ports:
- clk  input  1  system clock; everything, including outputs, is clocked on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- SCLK  input  1  SPI clock from master; idles high.
- SS  input  1  slave select, active low.
- MOSI  input  1  master-out data, MSB first.
- MISO  output  1  slave-out data, MSB first.
- MISO_OE  output  1  1 while a read data phase is active; MISO is don't-care when 0.
- reg_addr  output  ADDR_W  current register address.
- reg_rdata  input  8  register contents at reg_addr; combinational, valid the cycle after reg_addr changes.
- reg_wdata  output  8  write data, valid while reg_we=1.
- reg_we  output  1  one-clk write strobe.
- busy  output  1  1 while SS is low (synchronized).

Behaviour:
- Reset: MISO=0, MISO_OE=0, reg_addr=0, reg_wdata=0, reg_we=0, busy=0, state=IDLE, bit counter=0, synchronizers all high except MOSI (0).
- Synchronize SCLK, SS and MOSI through SYNC_STAGES flops.
  - rise = sync SCLK 0->1; fall = sync SCLK 1->0.
  - MOSI is sampled on rise using the MOSI synchronized in step with SCLK.
  - Requirement on the master: SCLK high and low phases each ≥ SYNC_STAGES+2 clk cycles.
- States: IDLE, CMD, LOAD, DATA.
  - IDLE: sync SS falls -> CMD; bit counter=0; busy=1.
  - CMD: each rise shifts MOSI into the command register. On the 8th rise: capture rw=bit7, ms=bit6, reg_addr=bits[5:0]. rw=1 -> LOAD; rw=0 -> DATA.
  - LOAD: single cycle. Shift register <= reg_rdata; MISO <= reg_rdata[7]; MISO_OE=1 -> DATA.
  - DATA (read):
    - Each fall after the first data-byte bit shifts MISO to the next bit.
    - On the 8th rise of a byte: if ms=1, reg_addr increments, wrapping 63->0. Then the shift register reloads from reg_rdata one cycle later, before the next fall. MISO updates on that fall for bit7.
    - MISO_OE stays 1 until SS rises.
  - DATA (write):
    - Each rise shifts MOSI in.
    - On the 8th rise: reg_wdata <= byte and reg_we=1 for exactly one clk, with reg_addr = that byte's address. reg_addr then increments if ms=1.
- Any state, sync SS rises -> IDLE next cycle.
  - MISO_OE=0, MISO=0, busy=0, bit counter cleared.
  - A partial byte (fewer than 8 rises) is discarded: no reg_we, no address change.
  - reg_addr holds its last value.
- SCLK edges while SS high are ignored.
- SS rising on the same cycle as the 8th rise of a write byte: the write completes (reg_we pulses) and the state returns to IDLE.
- Command byte only, then SS high: no access, no reg_we.
- Reset asserted mid-transfer: all outputs return to reset values immediately, regardless of clk.

Test Plan:
- Single read: regfile[0x0F]=0xD3; master sends 0x8F then 8 clocks -> master receives 0xD3 MSB first; MISO_OE=1 only during the data byte; reg_we never asserts.
- Burst read with wrap: regfile[0x3E]=0x11, [0x3F]=0x22, [0x00]=0x33; command 0xFE plus 3 bytes -> master receives 0x11, 0x22, 0x33; reg_addr sequence 0x3E, 0x3F, 0x00.
- Single write: command 0x20, data 0x0F -> exactly one reg_we pulse with reg_addr=0x20, reg_wdata=0x0F; reg_addr stays 0x20.
- Burst write: command 0x60, data 0xA1, 0xA2 -> reg_we pulses at addr 0x20 (0xA1) and 0x21 (0xA2); same command with ms=0 -> both writes at 0x20.
- Aborted transfer: command 0x20 then 5 data bits, then SS high -> no reg_we, state IDLE, busy=0. The next full transaction works normally.
- Reset mid-read: assert reset during bit 3 of the data byte -> MISO_OE=0, reg_addr=0, busy=0 without waiting for a clk edge. After reset release, a new read of 0x8F returns the correct data.
